// File: rtl/mem_bus_responder.sv
// Memory-side responder for the mem_cmd/mem_addr bus: decodes reads and writes
// onto a 256-word RAM, an LED register and a synchronized switch port.
module mem_bus_responder #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 9,
    parameter int                RAM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    input  logic [7:0]        SW,
    output logic [7:0]        LEDR,
    output logic              bus_err
);

    localparam int                RAM_AW  = $clog2(RAM_DEPTH);
    localparam logic [ADDR_W:0]   RAM_TOP = (ADDR_W + 1)'(RAM_DEPTH);
    localparam logic [1:0]        CMD_NONE  = 2'b00;
    localparam logic [1:0]        CMD_ILL   = 2'b01;
    localparam logic [1:0]        CMD_WRITE = 2'b10;
    localparam logic [1:0]        CMD_READ  = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RD   = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [DATA_W-1:0]   read_data_q;
    logic                read_valid_q;
    logic [7:0]          led_q;
    logic                bus_err_q;
    logic [7:0]          sw_sync1_q;
    logic [7:0]          sw_sync2_q;
    logic [DATA_W-1:0]   ram_q [RAM_DEPTH];

    logic                is_ram_s;
    logic                is_led_s;
    logic                is_sw_s;
    logic [RAM_AW-1:0]   ram_idx_s;
    logic [DATA_W-1:0]   rd_word_s;

    // Address decode and read-target mux
    always_comb begin
        is_ram_s  = ({1'b0, mem_addr} < RAM_TOP);
        is_led_s  = (mem_addr == LED_ADDR);
        is_sw_s   = (mem_addr == SW_ADDR);
        ram_idx_s = mem_addr[RAM_AW-1:0];
        rd_word_s = '0;
        if (is_ram_s) begin
            rd_word_s = ram_q[ram_idx_s];
        end else if (is_led_s) begin
            rd_word_s[7:0] = led_q;
        end else if (is_sw_s) begin
            rd_word_s[7:0] = sw_sync2_q;
        end else begin
            rd_word_s = '0;
        end
    end

    // RAM storage; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && (mem_cmd == CMD_WRITE) && is_ram_s) begin
            ram_q[ram_idx_s] <= write_data;
        end
    end

    // Read FSM, LED register, error flag and switch synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            led_q        <= 8'h00;
            bus_err_q    <= 1'b0;
            sw_sync1_q   <= 8'h00;
            sw_sync2_q   <= 8'h00;
        end else begin
            sw_sync1_q <= SW;
            sw_sync2_q <= sw_sync1_q;
            case (mem_cmd)
                CMD_READ: begin
                    rd_addr_q   <= mem_addr;
                    read_data_q <= rd_word_s;
                    state_q     <= S_RD;
                    // A new address while already reading costs one invalid cycle
                    read_valid_q <= (state_q == S_IDLE) || (mem_addr == rd_addr_q);
                    if (!(is_ram_s || is_led_s || is_sw_s)) begin
                        bus_err_q <= 1'b1;
                    end
                end
                CMD_WRITE: begin
                    state_q      <= S_IDLE;
                    read_valid_q <= 1'b0;
                    if (is_led_s) begin
                        led_q <= write_data[7:0];
                    end else if (!is_ram_s) begin
                        bus_err_q <= 1'b1;
                    end
                end
                CMD_ILL: begin
                    state_q      <= S_IDLE;
                    read_valid_q <= 1'b0;
                    bus_err_q    <= 1'b1;
                end
                CMD_NONE: begin
                    state_q      <= S_IDLE;
                    read_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    read_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign LEDR       = led_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed plus randomized bench for mem_bus_responder against a cycle-level
// behavioural model of the bus rules (memory image, LED, sticky error, read stream).
module tb_mem_bus_responder;

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] ILL   = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] READ  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_valid;
    logic [7:0]  sw_v;
    logic [7:0]  LEDR;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_ram [256];
    logic [7:0]  m_led;
    logic        m_err;
    logic [7:0]  m_sw_hist [2];
    logic        m_prev_read;
    logic [8:0]  m_prev_addr;
    logic        m_valid;
    logic [15:0] m_data;

    mem_bus_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .SW         (sw_v),
        .LEDR       (LEDR),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] target(input logic [8:0] a, output logic bad);
        bad = 1'b0;
        if (a < 9'd256)        return m_ram[a[7:0]];
        else if (a == 9'h100)  return {8'h00, m_led};
        else if (a == 9'h140)  return {8'h00, m_sw_hist[1]};
        bad = 1'b1;
        return 16'h0000;
    endfunction

    // One clock: drive inputs, advance the model across the edge, then compare
    task automatic step(input string tag, input logic r, input logic [1:0] c,
                        input logic [8:0] a, input logic [15:0] d);
        logic bad;
        logic [15:0] t;
        reset = r; mem_cmd = c; mem_addr = a; write_data = d;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_data = 16'h0000; m_led = 8'h00; m_err = 1'b0;
            m_sw_hist[0] = 8'h00; m_sw_hist[1] = 8'h00; m_prev_read = 1'b0;
        end else begin
            t = target(a, bad);
            if (c == READ) begin
                m_valid = !(m_prev_read && (m_prev_addr != a));
                m_data = t;
                if (bad) m_err = 1'b1;
                m_prev_read = 1'b1;
                m_prev_addr = a;
            end else begin
                m_valid = 1'b0;
                m_prev_read = 1'b0;
                if (c == WRITE) begin
                    if (a < 9'd256) m_ram[a[7:0]] = d;
                    else if (a == 9'h100) m_led = d[7:0];
                    else m_err = 1'b1;
                end else if (c == ILL) begin
                    m_err = 1'b1;
                end
            end
            m_sw_hist[1] = m_sw_hist[0];
            m_sw_hist[0] = sw_v;
        end
        #1;
        chk({tag, ".valid"}, {15'b0, read_valid}, {15'b0, m_valid});
        chk({tag, ".led"}, {8'b0, LEDR}, {8'b0, m_led});
        chk({tag, ".err"}, {15'b0, bus_err}, {15'b0, m_err});
        if (m_valid || r) chk({tag, ".data"}, read_data, m_data);
    endtask

    initial begin
        logic [8:0] a;
        logic [1:0] c;
        int k;
        reset = 1'b1; mem_cmd = NONE; mem_addr = 9'h000; write_data = 16'h0000; sw_v = 8'h00;
        m_prev_addr = 9'h000;
        step("rst0", 1'b1, NONE, 9'h000, 16'h0000);
        step("rst1", 1'b1, NONE, 9'h000, 16'h0000);
        chk("rst_data", read_data, 16'h0000);

        step("wr5", 1'b0, WRITE, 9'h005, 16'hBEEF);
        chk("rd5_c1_valid", {15'b0, read_valid}, 16'h0000);
        step("rd5a", 1'b0, READ, 9'h005, 16'h0000);
        step("rd5b", 1'b0, READ, 9'h005, 16'h0000);
        chk("rd5_data", read_data, 16'hBEEF);
        chk("rd5_err", {15'b0, bus_err}, 16'h0000);

        step("wr0", 1'b0, WRITE, 9'h000, 16'h1111);
        step("wr1", 1'b0, WRITE, 9'h001, 16'h2222);
        step("rd0a", 1'b0, READ, 9'h000, 16'h0000);
        chk("rd0_data", read_data, 16'h1111);
        step("rd0b", 1'b0, READ, 9'h000, 16'h0000);
        step("rd1a", 1'b0, READ, 9'h001, 16'h0000);
        chk("rd1_gap", {15'b0, read_valid}, 16'h0000);
        step("rd1b", 1'b0, READ, 9'h001, 16'h0000);
        chk("rd1_data", read_data, 16'h2222);

        step("wrled", 1'b0, WRITE, 9'h100, 16'h00A5);
        chk("led_a5", {8'b0, LEDR}, 16'h00A5);
        step("rdled", 1'b0, READ, 9'h100, 16'h0000);
        chk("rdled_data", read_data, 16'h00A5);

        sw_v = 8'h3C;
        step("sw_w1", 1'b0, NONE, 9'h000, 16'h0000);
        step("sw_w2", 1'b0, NONE, 9'h000, 16'h0000);
        step("rdsw", 1'b0, READ, 9'h140, 16'h0000);
        chk("rdsw_data", read_data, 16'h003C);
        sw_v = 8'hFF;
        step("rdsw_imm", 1'b0, READ, 9'h140, 16'h0000);
        chk("rdsw_stale", read_data, 16'h003C);

        step("e1_rst", 1'b1, NONE, 9'h000, 16'h0000);
        step("e1_wrsw", 1'b0, WRITE, 9'h140, 16'h1234);
        chk("e1_err", {15'b0, bus_err}, 16'h0001);
        chk("e1_led", {8'b0, LEDR}, 16'h0000);
        step("e1_hold", 1'b0, NONE, 9'h000, 16'h0000);
        step("e2_rst", 1'b1, NONE, 9'h000, 16'h0000);
        chk("e2_clr", {15'b0, bus_err}, 16'h0000);
        step("e2_rd", 1'b0, READ, 9'h1F0, 16'h0000);
        chk("e2_data0", read_data, 16'h0000);
        chk("e2_err", {15'b0, bus_err}, 16'h0001);
        step("e2_hold", 1'b0, NONE, 9'h000, 16'h0000);
        step("e3_rst", 1'b1, NONE, 9'h000, 16'h0000);
        step("e3_ill", 1'b0, ILL, 9'h005, 16'h5555);
        chk("e3_err", {15'b0, bus_err}, 16'h0001);
        step("e3_hold", 1'b0, NONE, 9'h000, 16'h0000);

        step("mr_rda", 1'b0, READ, 9'h005, 16'h0000);
        step("mr_rdb", 1'b0, READ, 9'h005, 16'h0000);
        step("mr_rst", 1'b1, READ, 9'h005, 16'h0000);
        step("mr_rel", 1'b0, READ, 9'h005, 16'h0000);
        chk("mr_beef", read_data, 16'hBEEF);

        for (int i = 0; i < 256; i++) begin
            step("pre", 1'b0, WRITE, 9'(i), 16'($urandom));
        end

        a = 9'h000;
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 99);
            if (k < 45) c = READ;
            else if (k < 70) c = WRITE;
            else if (k < 93) c = NONE;
            else c = ILL;
            k = $urandom_range(0, 19);
            if (k < 8) a = a;
            else if (k < 15) a = 9'($urandom_range(0, 255));
            else if (k < 17) a = 9'h100;
            else if (k < 19) a = 9'h140;
            else a = 9'h101 + 9'($urandom_range(0, 62));
            if ($urandom_range(0, 7) == 0) sw_v = 8'($urandom);
            step("rnd", ($urandom_range(0, 49) == 0), c, a, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
